// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, state encoding, control codes and ID-stage dispatch shared by the sequencer
package cpu_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EXE_AL = 4'd2;
  localparam logic [3:0] S_EXE_BR = 4'd3;
  localparam logic [3:0] S_EXE_LS = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB_AL  = 4'd6;
  localparam logic [3:0] S_WB_LD  = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;
  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;
  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_src;
    logic       db_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic       mrd;
    logic       mwr;
  } ctrl_t;
  // Jumps, jr and anything unrecognised finish in ID, so they all map back to IF.
  function automatic logic [3:0] id_next(input logic [5:0] op, input logic [5:0] func, input logic [5:0] halt_op);
    logic rk;
    rk = op == OP_R && func inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL};
    return op == halt_op ? S_HALT :
           op inside {OP_BEQ, OP_BNE} ? S_EXE_BR :
           op inside {OP_LW, OP_SW} ? S_EXE_LS :
           rk || op inside {OP_ADDI, OP_ORI, OP_ANDI} ? S_EXE_AL : S_IF;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from (state, op, func, zero) to the datapath control bundle
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output ctrl_t      ctrl
);
  logic r, jal, jr, br, taken;
  assign r = op == OP_R;
  assign jal = op == OP_JAL;
  assign jr = r && func == F_JR;
  assign br = op inside {OP_BEQ, OP_BNE};
  assign taken = (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
  always_comb begin
    ctrl = '0;
    ctrl.pc_wre = (state == S_ID && id_next(op, func, HALT_OP) == S_IF) || state == S_EXE_BR ||
                  (state == S_MEM && op == OP_SW) || state == S_WB_AL || state == S_WB_LD;
    ctrl.ir_wre = state == S_IF;
    ctrl.reg_wre = state == S_WB_AL || state == S_WB_LD || (state == S_ID && jal);
    ctrl.reg_dst = jal ? RD_RA : r ? RD_RD : RD_RT;
    ctrl.wr_reg_src = !jal;
    ctrl.db_src = op == OP_LW;
    ctrl.alu_src_a = r && func == F_SLL;
    ctrl.alu_src_b = op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW};
    ctrl.alu_op = r ? (func == F_SUB ? ALU_SUB : func == F_AND ? ALU_AND : func == F_OR ? ALU_OR :
                       func == F_SLT ? ALU_SLT : func == F_SLL ? ALU_SLL : ALU_ADD) :
                  op == OP_ORI ? ALU_OR : op == OP_ANDI ? ALU_AND : br ? ALU_SUB : ALU_ADD;
    ctrl.ext_sel = !(op inside {OP_ORI, OP_ANDI});
    ctrl.pc_src = state == S_ID ? (op == OP_J || jal ? PC_J : jr ? PC_JR : PC_SEQ) :
                  state == S_EXE_BR && taken ? PC_BR : PC_SEQ;
    ctrl.mrd = state == S_MEM && op == OP_LW;
    ctrl.mwr = state == S_MEM && op == OP_SW;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EXE/MEM/WB state register and next-state logic for the multi-cycle CPU
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCWre,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic [1:0] PCSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [3:0] state,
  output logic       halted
);
  logic [3:0] state_r, nxt;
  ctrl_t dec, c;
  ctrl_decode #(.HALT_OP(HALT_OP)) u_dec (.state(state_r), .op(op), .func(func), .zero(zero), .ctrl(dec));
  always_comb begin
    nxt = state_r == S_IF ? S_ID :
          state_r == S_ID ? id_next(op, func, HALT_OP) :
          state_r == S_EXE_AL ? S_WB_AL :
          state_r == S_EXE_LS ? S_MEM :
          state_r == S_MEM ? (op == OP_LW ? S_WB_LD : S_IF) :
          state_r == S_HALT ? S_HALT : S_IF;
  end
  always_ff @(posedge clk) begin
    state_r <= Reset ? S_IF : nxt;
  end
  // Reset is synchronous, so mask the decode during the reset cycle itself to keep every enable low.
  assign c = Reset ? '0 : dec;
  assign {PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, PCSrc, mRD, mWR} = c;
  assign state = Reset ? S_IF : state_r;
  assign halted = !Reset && state_r == S_HALT;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed sequence of instructions through the multi-cycle sequencer
module tb_multicycle_ctrl;
  logic clk, Reset, zero;
  logic [5:0] op, func;
  logic PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, halted;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
  int n_asrt = 0;
  int n_fail = 0;
  multicycle_ctrl dut (
    .clk(clk), .Reset(Reset), .op(op), .func(func), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR), .state(state), .halted(halted)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    Reset = 1; op = 6'b000000; func = 6'b100000; zero = 0;
    #1;
    chk("rst0_state", state, 0); chk("rst0_irwre", IRWre, 0); chk("rst0_halted", halted, 0);
    cyc();
    chk("rst1_state", state, 0); chk("rst1_pcwre", PCWre, 0); chk("rst1_irwre", IRWre, 0);
    chk("rst1_extsel", ExtSel, 0); chk("rst1_wrsrc", WrRegDSrc, 0);
    cyc();
    chk("rst2_state", state, 0); chk("rst2_regdst", RegDst, 0);
    Reset = 0;
    #1;
    // add
    chk("add_if_state", state, 0); chk("add_if_irwre", IRWre, 1); chk("add_if_pcwre", PCWre, 0);
    cyc();
    chk("add_id_state", state, 1); chk("add_id_irwre", IRWre, 0); chk("add_id_pcwre", PCWre, 0); chk("add_id_regwre", RegWre, 0);
    cyc();
    chk("add_exe_state", state, 2); chk("add_exe_aluop", ALUOp, 3'b000); chk("add_exe_srcb", ALUSrcB, 0); chk("add_exe_regwre", RegWre, 0);
    cyc();
    chk("add_wb_state", state, 6); chk("add_wb_regwre", RegWre, 1); chk("add_wb_pcwre", PCWre, 1);
    chk("add_wb_regdst", RegDst, 2'b10); chk("add_wb_wrsrc", WrRegDSrc, 1); chk("add_wb_dbsrc", DBDataSrc, 0);
    cyc();
    chk("add_next_if", state, 0);
    // lw
    op = 6'b100011;
    cyc();
    chk("lw_id_state", state, 1); chk("lw_id_pcwre", PCWre, 0);
    cyc();
    chk("lw_exe_state", state, 4); chk("lw_exe_srcb", ALUSrcB, 1); chk("lw_exe_extsel", ExtSel, 1); chk("lw_exe_aluop", ALUOp, 0);
    cyc();
    chk("lw_mem_state", state, 5); chk("lw_mem_mrd", mRD, 1); chk("lw_mem_mwr", mWR, 0); chk("lw_mem_pcwre", PCWre, 0);
    cyc();
    chk("lw_wb_state", state, 7); chk("lw_wb_regwre", RegWre, 1); chk("lw_wb_dbsrc", DBDataSrc, 1);
    chk("lw_wb_regdst", RegDst, 2'b01); chk("lw_wb_pcwre", PCWre, 1); chk("lw_wb_mrd", mRD, 0);
    cyc();
    chk("lw_next_if", state, 0);
    // beq, zero both ways
    op = 6'b000100; zero = 1;
    cyc();
    chk("beq_id_state", state, 1);
    cyc();
    chk("beq_exe_state", state, 3); chk("beq_z1_pcsrc", PCSrc, 2'b01); chk("beq_pcwre", PCWre, 1); chk("beq_aluop", ALUOp, 3'b001);
    zero = 0;
    #1;
    chk("beq_z0_pcsrc", PCSrc, 2'b00); chk("beq_z0_pcwre", PCWre, 1);
    cyc();
    chk("beq_next_if", state, 0);
    // bne mirrored
    op = 6'b000101; zero = 0;
    cyc(); cyc();
    chk("bne_exe_state", state, 3); chk("bne_z0_pcsrc", PCSrc, 2'b01);
    zero = 1;
    #1;
    chk("bne_z1_pcsrc", PCSrc, 2'b00);
    cyc();
    chk("bne_next_if", state, 0);
    // jal
    op = 6'b000011;
    cyc();
    chk("jal_id_state", state, 1); chk("jal_pcsrc", PCSrc, 2'b11); chk("jal_regwre", RegWre, 1);
    chk("jal_regdst", RegDst, 2'b00); chk("jal_wrsrc", WrRegDSrc, 0); chk("jal_pcwre", PCWre, 1);
    cyc();
    chk("jal_next_if", state, 0); chk("jal_if_pcsrc", PCSrc, 2'b00);
    // jr
    op = 6'b000000; func = 6'b001000;
    cyc();
    chk("jr_pcsrc", PCSrc, 2'b10); chk("jr_pcwre", PCWre, 1); chk("jr_regwre", RegWre, 0);
    cyc();
    chk("jr_next_if", state, 0);
    // sll
    func = 6'b000000;
    cyc(); cyc();
    chk("sll_exe_state", state, 2); chk("sll_srca", ALUSrcA, 1); chk("sll_aluop", ALUOp, 3'b101);
    cyc(); cyc();
    chk("sll_next_if", state, 0);
    // ori: zero-extended immediate
    op = 6'b001101;
    cyc(); cyc();
    chk("ori_exe_state", state, 2); chk("ori_extsel", ExtSel, 0); chk("ori_aluop", ALUOp, 3'b011); chk("ori_srcb", ALUSrcB, 1); chk("ori_srca", ALUSrcA, 0);
    cyc();
    chk("ori_wb_regdst", RegDst, 2'b01); chk("ori_wb_regwre", RegWre, 1);
    cyc();
    // unknown opcode behaves as NOP
    op = 6'b111110;
    cyc();
    chk("nop_id_state", state, 1); chk("nop_pcwre", PCWre, 1); chk("nop_regwre", RegWre, 0);
    cyc();
    chk("nop_next_if", state, 0);
    // sw interrupted by reset in MEM
    op = 6'b101011;
    cyc(); cyc(); cyc();
    chk("sw_mem_state", state, 5); chk("sw_mem_mwr", mWR, 1); chk("sw_mem_pcwre", PCWre, 1); chk("sw_mem_mrd", mRD, 0);
    Reset = 1;
    #1;
    chk("sw_rst_mwr", mWR, 0); chk("sw_rst_pcwre", PCWre, 0); chk("sw_rst_state", state, 0);
    cyc();
    Reset = 0;
    #1;
    chk("sw_rst_next_if", state, 0); chk("sw_rst_if_irwre", IRWre, 1);
    // halt
    op = 6'b111111;
    cyc();
    chk("halt_id_state", state, 1); chk("halt_id_halted", halted, 0); chk("halt_id_pcwre", PCWre, 0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("halt_state", state, 8); chk("halt_halted", halted, 1); chk("halt_pcwre", PCWre, 0); chk("halt_irwre", IRWre, 0);
    end
    Reset = 1;
    #1;
    chk("halt_rst_halted", halted, 0); chk("halt_rst_state", state, 0);
    cyc();
    Reset = 0;
    #1;
    chk("halt_rst_next_if", state, 0); chk("halt_rst_irwre", IRWre, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS-subset CPU: a state machine that steps each instruction through IF/ID/EXE/MEM/WB and drives every write enable and mux select of the datapath. It sits beside the instruction memory/decoder and consumes its `op`/`func` fields plus the ALU `zero` flag. It replaces the single-cycle combinational control so that instruction memory, ALU and data memory are each used once per cycle.

## Interface
Parameters:
- `HALT_OP`, 6'b111111, opcode that freezes the machine.

Ports:
- `clk`  in  1  rising-edge clock
- `Reset`  in  1  reset, synchronous, active-high
- `op`  in  6  opcode, from the latched instruction
- `func`  in  6  R-type function field
- `zero`  in  1  ALU result == 0
- `PCWre`  out  1  PC register load enable
- `IRWre`  out  1  instruction register load enable
- `RegWre`  out  1  register file write enable
- `RegDst`  out  2  write register select: 00 = `$31`, 01 = `rt`, 10 = `rd`
- `WrRegDSrc`  out  1  write-data source: 0 = PC+4 (jal), 1 = ALU/memory result
- `DBDataSrc`  out  1  result source: 0 = ALU, 1 = data memory
- `ALUSrcA`  out  1  ALU A input: 1 = shamt, 0 = `rs`
- `ALUSrcB`  out  1  ALU B input: 1 = extended immediate, 0 = `rt`
- `ALUOp`  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sll
- `ExtSel`  out  1  immediate extension: 1 = sign, 0 = zero
- `PCSrc`  out  2  next-PC select: 00 = PC+4, 01 = branch, 10 = `jr` (`rs`), 11 = jump
- `mRD`  out  1  data memory read
- `mWR`  out  1  data memory write
- `state`  out  4  current state, for debug
- `halted`  out  1  machine is in HALT

## Operation
- Supported instructions: R-type add, sub, and, or, slt, sll, jr; addi, ori, andi, lw, sw, beq, bne, j, jal, halt.
- Unknown opcode or func is executed as a NOP: ID returns to IF with `PCWre` = 1.
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- Transitions:
  - IF → ID always.
  - ID:
    - j / jal / jr → IF.
    - halt → HALT.
    - beq / bne → EXE_BR.
    - lw / sw → EXE_LS.
    - all other supported instructions → EXE_AL.
  - EXE_AL → WB_AL; WB_AL → IF.
  - EXE_BR → IF.
  - EXE_LS → MEM.
  - MEM: sw → IF; lw → WB_LD.
  - WB_LD → IF.
  - HALT → HALT until `Reset`.
- Outputs are decoded combinationally from the registered state plus `op`/`func`. `op` is stable from ID onward because the IR is latched in IF.
- Signal assertion rules:
  - `IRWre` = 1 only in IF.
  - `PCWre` = 1 only in the final state of each instruction: ID for j/jal/jr/NOP, EXE_BR, MEM for sw, WB_AL, WB_LD. It is never asserted in HALT.
  - `PCSrc` = 01 in EXE_BR only if (beq & `zero`) | (bne & !`zero`); otherwise 00. `PCSrc` = 11 for j/jal and 10 for jr, both in ID.
  - `RegWre` = 1 in WB_AL, in WB_LD, and in ID for jal. For jal, `RegDst` = 00 and `WrRegDSrc` = 0.
  - `mRD` = 1 in MEM for lw; `mWR` = 1 in MEM for sw.
  - `ExtSel` = 0 for ori and andi, 1 otherwise.
  - `ALUSrcA` = 1 for sll only.
- Every enable not listed above is 0 in every state.

## Timing
- Reset, sampled at a rising edge: next state = IF.
  - While `Reset` is high, all enables are 0 (`PCWre`, `IRWre`, `RegWre`, `mRD`, `mWR`), `halted` = 0 and `state` = IF.
  - All selects reset to 0.
- Reset has priority over any state, including mid-instruction (e.g. MEM with `mWR`) and HALT. No write enable is asserted in the cycle `Reset` is high.
- Cycles per instruction: R-type/imm 4, lw 5, sw 4, beq/bne 3, j/jal/jr 2, halt 2, then stays in HALT.
- `zero` is sampled combinationally in EXE_BR and must be valid in that cycle.
- `halted` = 1 from the cycle after ID of a halt instruction and holds until `Reset`.

## Structure
- Shared package `cpu_pkg`: opcode and func constants, state encoding (4-bit enum), `ALUOp` codes, `PCSrc` and `RegDst` codes.
- One sub-module, `ctrl_decode`: purely combinational mapping (state, op, func, zero) → control bundle.
- The top level holds only the state register and the next-state logic.

## Test plan
- `Reset` held 2 cycles, then add (op 000000, func 100000) → states IF, ID, EXE_AL, WB_AL. `RegWre` = 1 and `PCWre` = 1 only in WB_AL; `RegDst` = 10.
- lw (op 100011) → 5 states ending in WB_LD. `mRD` = 1 in MEM, `DBDataSrc` = 1, `RegDst` = 01, `ExtSel` = 1.
- beq (op 000100):
  - with `zero` = 1 → EXE_BR has `PCSrc` = 01, `PCWre` = 1;
  - with `zero` = 0 → `PCSrc` = 00;
  - bne with the opposite `zero` gives the mirrored result.
- jal (op 000011) → ID has `PCSrc` = 11, `RegWre` = 1, `RegDst` = 00, `WrRegDSrc` = 0; next state is IF.
- halt (op 111111) → HALT, with `halted` = 1 and `PCWre` = 0 for 10+ cycles.
- `Reset` asserted in MEM of a sw → `mWR` = 0 that cycle, and the next state is IF.
